// File: rtl/alarm_pkg.sv
// Shared types and constants for the multi-alarm engine.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } alarm_state_t;

    localparam int HRS_MOD       = 24;
    localparam int MIN_MOD       = 60;
    localparam int DAYS_PER_WEEK = 7;

    // A setpoint is only accepted when it names a real time of day.
    function automatic logic setpoint_valid(input logic [6:0] hrs, input logic [6:0] min);
        return (hrs < 7'(HRS_MOD)) && (min < 7'(MIN_MOD));
    endfunction

endpackage

// File: rtl/alarm_bank_if.sv
// Bundle of time inputs, setpoint write bus, buttons and alarm outputs.
interface alarm_bank_if #(
    parameter int N_ALARM = 4,
    parameter int SEL_W   = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
);
    logic               tick;
    logic [6:0]         tHrs;
    logic [6:0]         tMin;
    logic [6:0]         tSec;
    logic [2:0]         tDay;
    logic               alarmOn;
    logic               wrEn;
    logic [SEL_W-1:0]   wrSel;
    logic [6:0]         wrHrs;
    logic [6:0]         wrMin;
    logic [6:0]         wrDays;
    logic               wrArm;
    logic               snooze;
    logic               dismiss;
    logic [N_ALARM-1:0] ringing;
    logic [SEL_W-1:0]   ringId;
    logic               buzz;

    modport master (
        output tick, tHrs, tMin, tSec, tDay, alarmOn,
        output wrEn, wrSel, wrHrs, wrMin, wrDays, wrArm,
        output snooze, dismiss,
        input  ringing, ringId, buzz
    );

    modport slave (
        input  tick, tHrs, tMin, tSec, tDay, alarmOn,
        input  wrEn, wrSel, wrHrs, wrMin, wrDays, wrArm,
        input  snooze, dismiss,
        output ringing, ringId, buzz
    );
endinterface

// File: rtl/alarm_chan.sv
// One alarm channel: setpoint registers, ring/snooze FSM, tick timer and snooze counter.
//
// state   | meaning
// IDLE    | waiting for the setpoint time on an enabled weekday
// RINGING | sounding; timer counts down to auto-off
// SNOOZED | silenced; timer counts down to the next ring
module alarm_chan
    import alarm_pkg::*;
#(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 540,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_i,
    input  logic [6:0] t_hrs_i,
    input  logic [6:0] t_min_i,
    input  logic [6:0] t_sec_i,
    input  logic [2:0] t_day_i,
    input  logic       alarm_on_i,
    input  logic       wr_en_i,
    input  logic [6:0] wr_hrs_i,
    input  logic [6:0] wr_min_i,
    input  logic [6:0] wr_days_i,
    input  logic       wr_arm_i,
    input  logic       snooze_i,
    input  logic       dismiss_i,
    output logic       ringing_o
);

    localparam int TMR_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int CNT_W   = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

    alarm_state_t     state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [6:0]       hrs_q, hrs_d;
    logic [6:0]       min_q, min_d;
    logic [6:0]       days_q, days_d;
    logic             arm_q, arm_d;

    logic day_hit;
    logic trig;
    logic timer_last;

    // tDay values 7 is not a weekday and never matches.
    assign day_hit    = (t_day_i < 3'(DAYS_PER_WEEK)) && days_q[t_day_i];
    assign trig       = tick_i && alarm_on_i && arm_q && day_hit &&
                        (t_hrs_i == hrs_q) && (t_min_i == min_q) && (t_sec_i == 7'd0);
    assign timer_last = (timer_q <= TMR_W'(1));

    // State, timer, counter and setpoint registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            count_q <= '0;
            hrs_q   <= '0;
            min_q   <= '0;
            days_q  <= '0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
            hrs_q   <= hrs_d;
            min_q   <= min_d;
            days_q  <= days_d;
            arm_q   <= arm_d;
        end
    end

    // Next-state logic; branch order encodes write > dismiss/disable > snooze > expiry > trigger.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        count_d = count_q;
        hrs_d   = hrs_q;
        min_d   = min_q;
        days_d  = days_q;
        arm_d   = arm_q;

        if (wr_en_i) begin
            hrs_d   = wr_hrs_i;
            min_d   = wr_min_i;
            days_d  = wr_days_i;
            arm_d   = wr_arm_i;
            state_d = IDLE;
            timer_d = '0;
            count_d = '0;
        end else if (dismiss_i || !alarm_on_i) begin
            state_d = IDLE;
            timer_d = '0;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (trig) begin
                        state_d = RINGING;
                        timer_d = TMR_W'(RING_SEC);
                        count_d = '0;
                    end
                end
                RINGING: begin
                    if (snooze_i && (count_q < CNT_W'(MAX_SNOOZE))) begin
                        state_d = SNOOZED;
                        timer_d = TMR_W'(SNOOZE_SEC);
                        count_d = count_q + CNT_W'(1);
                    end else if (tick_i) begin
                        if (timer_last) begin
                            state_d = IDLE;
                            timer_d = '0;
                        end else begin
                            timer_d = timer_q - TMR_W'(1);
                        end
                    end
                end
                SNOOZED: begin
                    if (tick_i) begin
                        if (timer_last) begin
                            state_d = RINGING;
                            timer_d = TMR_W'(RING_SEC);
                        end else begin
                            timer_d = timer_q - TMR_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                    count_d = '0;
                end
            endcase
        end
    end

    assign ringing_o = (state_q == RINGING);

endmodule

// File: rtl/alarm_bank.sv
// Multi-alarm engine: setpoint write decode, per-channel FSMs, ringId encoder and buzz merge.
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int N_ALARM    = 4,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 540,
    parameter int MAX_SNOOZE = 3
) (
    input  logic         clk,
    input  logic         rst,
    alarm_bank_if.slave  bus
);

    localparam int SEL_W = (N_ALARM > 1) ? $clog2(N_ALARM) : 1;

    logic               wr_ok;
    logic [N_ALARM-1:0] wr_hit;
    logic [N_ALARM-1:0] ringing_w;
    logic [SEL_W-1:0]   ring_id;

    // An out-of-range write is dropped as a whole, so it neither updates nor idles a channel.
    assign wr_ok = bus.wrEn && setpoint_valid(bus.wrHrs, bus.wrMin) &&
                   (int'(bus.wrSel) < N_ALARM);

    for (genvar g = 0; g < N_ALARM; g++) begin : g_chan
        assign wr_hit[g] = wr_ok && (bus.wrSel == SEL_W'(g));

        alarm_chan #(
            .RING_SEC   (RING_SEC),
            .SNOOZE_SEC (SNOOZE_SEC),
            .MAX_SNOOZE (MAX_SNOOZE)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst),
            .tick_i     (bus.tick),
            .t_hrs_i    (bus.tHrs),
            .t_min_i    (bus.tMin),
            .t_sec_i    (bus.tSec),
            .t_day_i    (bus.tDay),
            .alarm_on_i (bus.alarmOn),
            .wr_en_i    (wr_hit[g]),
            .wr_hrs_i   (bus.wrHrs),
            .wr_min_i   (bus.wrMin),
            .wr_days_i  (bus.wrDays),
            .wr_arm_i   (bus.wrArm),
            .snooze_i   (bus.snooze),
            .dismiss_i  (bus.dismiss),
            .ringing_o  (ringing_w[g])
        );
    end

    // Lowest-index ringing channel wins; 0 when nothing rings.
    always_comb begin
        ring_id = '0;
        for (int i = N_ALARM - 1; i >= 0; i--) begin
            if (ringing_w[i]) ring_id = SEL_W'(i);
        end
    end

    assign bus.ringing = ringing_w;
    assign bus.ringId  = ring_id;
    assign bus.buzz    = bus.alarmOn & (|ringing_w);

endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank with a behavioural per-channel model checked every cycle.
module tb_alarm_bank;

    localparam int N          = 4;
    localparam int RING_SEC   = 60;
    localparam int SNOOZE_SEC = 540;
    localparam int MAX_SNOOZE = 3;

    localparam int M_IDLE = 0;
    localparam int M_RING = 1;
    localparam int M_SNZ  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    alarm_bank_if #(.N_ALARM(N)) bus ();

    alarm_bank #(
        .N_ALARM    (N),
        .RING_SEC   (RING_SEC),
        .SNOOZE_SEC (SNOOZE_SEC),
        .MAX_SNOOZE (MAX_SNOOZE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: each alarm is a mode plus "ticks left" and "snoozes used".
    int m_hrs  [N];
    int m_min  [N];
    int m_days [N];
    int m_arm  [N];
    int m_mode [N];
    int m_left [N];
    int m_cnt  [N];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < N; c++) begin
                m_hrs[c] = 0; m_min[c] = 0; m_days[c] = 0; m_arm[c] = 0;
                m_mode[c] = M_IDLE; m_left[c] = 0; m_cnt[c] = 0;
            end
        end else begin
            for (int c = 0; c < N; c++) begin
                if (bus.wrEn && int'(bus.wrSel) == c && bus.wrHrs < 24 && bus.wrMin < 60) begin
                    m_hrs[c] = bus.wrHrs; m_min[c] = bus.wrMin;
                    m_days[c] = bus.wrDays; m_arm[c] = bus.wrArm;
                    m_mode[c] = M_IDLE; m_cnt[c] = 0;
                end else if (bus.dismiss || !bus.alarmOn) begin
                    m_mode[c] = M_IDLE; m_cnt[c] = 0;
                end else if (m_mode[c] == M_RING && bus.snooze && m_cnt[c] < MAX_SNOOZE) begin
                    m_mode[c] = M_SNZ; m_left[c] = SNOOZE_SEC; m_cnt[c]++;
                end else if (bus.tick && m_mode[c] != M_IDLE) begin
                    m_left[c]--;
                    if (m_left[c] == 0) begin
                        if (m_mode[c] == M_RING) m_mode[c] = M_IDLE;
                        else begin m_mode[c] = M_RING; m_left[c] = RING_SEC; end
                    end
                end else if (bus.tick && m_mode[c] == M_IDLE && m_arm[c] != 0 &&
                             bus.tDay < 7 && ((m_days[c] >> bus.tDay) & 1) == 1 &&
                             int'(bus.tHrs) == m_hrs[c] && int'(bus.tMin) == m_min[c] &&
                             bus.tSec == 0) begin
                    m_mode[c] = M_RING; m_left[c] = RING_SEC; m_cnt[c] = 0;
                end
            end
        end
    end

    // Compare DUT outputs against the model mid-cycle.
    always @(negedge clk) begin
        logic [N-1:0] exp_ring;
        int exp_id;
        logic exp_buzz;
        exp_ring = '0;
        exp_id = 0;
        for (int c = N - 1; c >= 0; c--) begin
            if (m_mode[c] == M_RING) begin
                exp_ring[c] = 1'b1;
                exp_id = c;
            end
        end
        exp_buzz = bus.alarmOn && (exp_ring != '0);
        checks += 3;
        if (bus.ringing !== exp_ring) begin
            errors++;
            $display("FAIL model_ringing t=%0t actual=%b required=%b", $time, bus.ringing, exp_ring);
        end
        if (int'(bus.ringId) != exp_id || $isunknown(bus.ringId)) begin
            errors++;
            $display("FAIL model_ringId t=%0t actual=%0d required=%0d", $time, bus.ringId, exp_id);
        end
        if (bus.buzz !== exp_buzz) begin
            errors++;
            $display("FAIL model_buzz t=%0t actual=%b required=%b", $time, bus.buzz, exp_buzz);
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        bus.tick    = 1'b0;
        bus.snooze  = 1'b0;
        bus.dismiss = 1'b0;
        bus.wrEn    = 1'b0;
        bus.tSec    = 7'd1;
    endtask

    task automatic tk(input int n);
        repeat (n) begin
            bus.tick = 1'b1;
            cyc();
        end
    endtask

    task automatic wr(input int sel, input int h, input int m, input logic [6:0] days, input logic arm);
        bus.wrEn   = 1'b1;
        bus.wrSel  = 2'(sel);
        bus.wrHrs  = 7'(h);
        bus.wrMin  = 7'(m);
        bus.wrDays = days;
        bus.wrArm  = arm;
        cyc();
    endtask

    task automatic trig(input int h, input int m, input int d);
        bus.tHrs = 7'(h);
        bus.tMin = 7'(m);
        bus.tDay = 3'(d);
        bus.tSec = 7'd0;
        bus.tick = 1'b1;
        cyc();
    endtask

    initial begin
        bus.tick = 0; bus.tHrs = 0; bus.tMin = 0; bus.tSec = 7'd1; bus.tDay = 0;
        bus.alarmOn = 1'b1; bus.wrEn = 0; bus.wrSel = 0; bus.wrHrs = 0; bus.wrMin = 0;
        bus.wrDays = 0; bus.wrArm = 0; bus.snooze = 0; bus.dismiss = 0;
        #1 rst = 1'b0;
        #20 rst = 1'b1;
        cyc();
        chk("reset_ringing", int'(bus.ringing), 0);
        chk("reset_buzz", int'(bus.buzz), 0);

        // Weekday ring, then auto-off after 60 ticks.
        wr(0, 7, 30, 7'b0111110, 1'b1);
        trig(7, 30, 1);
        chk("weekday_ringing", int'(bus.ringing), 4'b0001);
        chk("weekday_ringId", int'(bus.ringId), 0);
        chk("weekday_buzz", int'(bus.buzz), 1);
        tk(59);
        chk("autooff_tick59", int'(bus.ringing), 4'b0001);
        tk(1);
        chk("autooff_tick60", int'(bus.ringing), 0);

        // Weekend mask blocks the trigger.
        trig(7, 30, 0);
        chk("sunday_buzz", int'(bus.buzz), 0);
        trig(7, 30, 6);
        chk("saturday_buzz", int'(bus.buzz), 0);

        // Snooze cycles and the snooze limit.
        trig(7, 30, 1);
        chk("snz_ring0", int'(bus.buzz), 1);
        for (int s = 1; s <= MAX_SNOOZE; s++) begin
            bus.snooze = 1'b1;
            cyc();
            chk("snz_silent", int'(bus.buzz), 0);
            tk(SNOOZE_SEC - 1);
            chk("snz_still_silent", int'(bus.buzz), 0);
            tk(1);
            chk("snz_rering", int'(bus.buzz), 1);
        end
        bus.snooze = 1'b1;
        cyc();
        chk("snz_limit_buzz", int'(bus.buzz), 1);
        bus.dismiss = 1'b1;
        cyc();
        chk("dismiss_buzz", int'(bus.buzz), 0);

        // Shared alarm time on two channels.
        wr(1, 6, 0, 7'h7F, 1'b1);
        wr(2, 6, 0, 7'h7F, 1'b1);
        trig(6, 0, 3);
        chk("shared_ringing", int'(bus.ringing), 4'b0110);
        chk("shared_ringId", int'(bus.ringId), 1);
        bus.snooze = 1'b1;
        bus.dismiss = 1'b1;
        cyc();
        chk("snz_dismiss_ringing", int'(bus.ringing), 0);

        // Master disable idles everything on the next edge.
        trig(6, 0, 3);
        chk("alarmoff_pre", int'(bus.ringing), 4'b0110);
        bus.alarmOn = 1'b0;
        cyc();
        chk("alarmoff_ringing", int'(bus.ringing), 0);
        bus.alarmOn = 1'b1;

        // Invalid writes are ignored and do not idle a ringing channel.
        trig(6, 0, 3);
        wr(1, 24, 0, 7'h00, 1'b0);
        chk("badhrs_ringing", int'(bus.ringing), 4'b0110);
        wr(2, 6, 60, 7'h00, 1'b0);
        chk("badmin_ringing", int'(bus.ringing), 4'b0110);
        bus.dismiss = 1'b1;
        cyc();
        trig(6, 0, 3);
        chk("badwr_kept", int'(bus.ringing), 4'b0110);
        bus.dismiss = 1'b1;
        cyc();

        // Asynchronous reset mid-ring clears outputs and setpoints.
        trig(7, 30, 1);
        chk("prereset_buzz", int'(bus.buzz), 1);
        rst = 1'b0;
        #1;
        chk("async_reset_buzz", int'(bus.buzz), 0);
        chk("async_reset_ringing", int'(bus.ringing), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        cyc();
        trig(7, 30, 1);
        chk("post_reset_no_trigger", int'(bus.buzz), 0);
        trig(6, 0, 3);
        chk("post_reset_no_trigger2", int'(bus.ringing), 0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
